transform_seq: RTL and testbench
================================

Name: transform_seq

Overview:
- Initiator side of the transform handshake. Per macroblock, issues one transform job per 4x4/DC block, in decode order.
- For each job it presents the residual_state code and block index, pulses trans_start, and waits for the transform block's valid.
- Sits between the CAVLC residual decoder (blk_rdy/blk_ack) and the transform FSM. Emits mb_done when all luma and chroma jobs have completed.

Parameters:
- none; all state codes come from the shared defines.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ena  in  1  global enable; when low, all FFs hold
- mb_start  in  1  one-cycle pulse to begin macroblock sequencing
- is_i16x16  in  1  macroblock is Intra16x16; sampled with mb_start
- cbp_luma  in  4  coded_block_pattern luma bits (bit k covers blocks 4k..4k+3); sampled with mb_start
- cbp_chroma  in  2  0 = none, 1 = DC only, 2 = DC+AC; sampled with mb_start
- blk_rdy  in  1  residual decoder holds coefficients for the presented block
- blk_ack  out  1  one-cycle pulse: coded block handed to transform
- trans_start  out  1  one-cycle start to transform
- trans_state  out  4  residual_state code of the current job
- luma_idx  out  4  luma 4x4 block index, 0..15
- chroma_idx  out  2  chroma block index within component, 0..3
- trans_valid  in  1  transform done flag; clears after start, sets at end
- busy  out  1  high from mb_start accept until mb_done
- mb_done  out  1  one-cycle pulse after the last job's valid

Behaviour:
- Reset values: all outputs 0; state IDLE; phase LUMA; counters 0.
- States:
  - IDLE: on mb_start, latch the macroblock inputs, set busy, go to SEL. mb_start while busy is ignored.
  - SEL: choose the next job code from phase, counter and latched cbp.
    - Coded job: go to WAIT_RDY.
    - Zero job (any *_0_s code): go to START.
    - No job remaining: go to DONE.
  - WAIT_RDY: hold until blk_rdy=1, then go to START.
  - START: trans_start=1 for exactly one ena cycle. blk_ack=1 in the same cycle for coded jobs only. Go to SETTLE.
  - SETTLE: one cycle, trans_valid ignored (it is stale until transform clears it). Go to WAIT_DONE.
  - WAIT_DONE: when trans_valid=1, advance counter/phase and go to SEL.
  - DONE: mb_done=1 for one cycle, busy=0, go to IDLE.
- Job order:
  - i16x16:
    - Intra16x16DCLevel_s, luma_idx=0.
    - Then 16 AC jobs with luma_idx 0..15: Intra16x16ACLevel_s if cbp_luma[idx>>2], else Intra16x16ACLevel_0_s.
  - Otherwise: 16 jobs with luma_idx 0..15: LumaLevel_s if cbp_luma[idx>>2], else LumaLevel_0_s.
  - Chroma:
    - cbp_chroma!=0: ChromaDCLevel_Cb_s then ChromaDCLevel_Cr_s first. DC always precedes AC because AC reads the DC store.
    - Then 4 Cb AC jobs (chroma_idx 0..3), then 4 Cr AC jobs.
    - AC jobs are *_Level_* when cbp_chroma==2, else *_0_s.
    - cbp_chroma==0 skips DC and issues 8 zero AC jobs.
  - Total jobs: i16x16 17+{8,10,10}; other 16+{8,10,10}.
- trans_state, luma_idx and chroma_idx are registered and stable from SEL through WAIT_DONE.
- Counter widths:
  - luma counter is 5-bit and terminates at 16; it never wraps to 0.
  - chroma counter is 3-bit, 0..7, terminating at 8 via a phase change.
- Simultaneous events:
  - blk_rdy held high across jobs: each coded job is acked exactly once.
  - trans_valid already 1 in SETTLE: ignored; only the WAIT_DONE sample counts.
- ena low: state, counters and registered outputs freeze. trans_start/blk_ack are decoded from state, so they stay asserted until the ena cycle that consumes them.
- rst mid-macroblock: immediate return to IDLE, all outputs 0. No pending ack.

Decomposition:
- Shared defines: residual_state codes, including the *_0_s variants; phase encoding (LUMA_DC, LUMA_AC, CHROMA_DC_CB, CHROMA_DC_CR, CHROMA_AC); sequencer state codes.
- One natural sub-module: transform_seq_jobsel, a combinational block mapping (phase, counter, latched cbp, is_i16x16) to {job code, coded flag, last flag}.

Test Plan:
- i16x16, cbp_luma=4'b0001, cbp_chroma=0, blk_rdy tied 1, transform model valid 5 cycles after start:
  - expect 25 starts: DC, AC idx0-3 coded, idx4-15 *_0_s, 8 Chroma*_0_s.
  - expect 5 blk_ack.
  - mb_done once.
- non-i16, cbp_luma=4'hF, cbp_chroma=2, blk_rdy delayed 3 cycles per block:
  - each start lands exactly 1 cycle after blk_rdy.
  - 26 acks, in order LumaLevel 0..15, DC Cb, DC Cr, Cb AC 0..3, Cr AC 0..3.
- trans_valid stuck 1 from previous job during SETTLE: no premature advance. Next start only after the model drops and re-raises valid.
- ena toggled 1/0 every cycle throughout scenario 2: job sequence and ack count identical to ena=1 run; trans_start high on exactly one ena cycle per job.
- rst asserted during the WAIT_DONE of job 7:
  - outputs 0 the same cycle, busy=0.
  - a new mb_start then replays the full sequence from job 0.
- mb_start pulsed while busy: ignored, no latch change; only one mb_done.

Source files
------------

// File: rtl/transform_seq_pkg.sv
// Shared codes for the transform job sequencer: residual_state job codes,
// job phases and sequencer FSM states.
package transform_seq_pkg;

   typedef enum logic [3:0] {
      RsI16DcLevel  = 4'd0,
      RsI16AcLevel  = 4'd1,
      RsLumaLevel   = 4'd2,
      RsCbDcLevel   = 4'd3,
      RsCrDcLevel   = 4'd4,
      RsCbAcLevel   = 4'd5,
      RsCrAcLevel   = 4'd6,
      RsI16AcLevel0 = 4'd7,
      RsLumaLevel0  = 4'd8,
      RsCbAcLevel0  = 4'd9,
      RsCrAcLevel0  = 4'd10
   } residual_state_e;

   typedef enum logic [2:0] {
      PhLumaDc,
      PhLumaAc,
      PhChromaDcCb,
      PhChromaDcCr,
      PhChromaAc,
      PhNone
   } phase_e;

   typedef enum logic [2:0] {
      StIdle,
      StSel,
      StWaitRdy,
      StStart,
      StSettle,
      StWaitDone,
      StDone
   } seq_state_e;

   localparam logic [4:0] LumaLast    = 5'd15;
   localparam logic [2:0] ChromaLast  = 3'd7;
   localparam logic [1:0] CbpChromaAc = 2'd2;

endpackage

// File: rtl/transform_seq_jobsel.sv
// Maps the sequencer position (phase, counters) and latched macroblock
// parameters to the next transform job code and its coded flag.
module transform_seq_jobsel
   import transform_seq_pkg::*;
(
   input  phase_e          i_phase,
   input  logic [4:0]      i_luma_cnt,
   input  logic [2:0]      i_chroma_cnt,
   input  logic [3:0]      i_cbp_luma,
   input  logic [1:0]      i_cbp_chroma,
   input  logic            i_is_i16x16,
   output residual_state_e o_job,
   output logic            o_coded,
   output logic            o_none,
   output logic [3:0]      o_luma_idx,
   output logic [1:0]      o_chroma_idx
);

   logic w_luma_cbp;
   logic w_chroma_ac;

   assign w_luma_cbp  = i_cbp_luma[i_luma_cnt[3:2]];
   assign w_chroma_ac = (i_cbp_chroma == CbpChromaAc);

   always_comb begin
      o_job        = RsLumaLevel0;
      o_coded      = 1'b0;
      o_none       = 1'b0;
      o_luma_idx   = i_luma_cnt[3:0];
      o_chroma_idx = i_chroma_cnt[1:0];
      case (i_phase)
         PhLumaDc: begin
            o_job      = RsI16DcLevel;
            o_coded    = 1'b1;
            o_luma_idx = 4'd0;
         end
         PhLumaAc: begin
            if (i_luma_cnt[4]) begin
               o_none = 1'b1;
            end else begin
               o_coded = w_luma_cbp;
               if (i_is_i16x16) o_job = w_luma_cbp ? RsI16AcLevel : RsI16AcLevel0;
               else             o_job = w_luma_cbp ? RsLumaLevel  : RsLumaLevel0;
            end
         end
         PhChromaDcCb: begin
            o_job   = RsCbDcLevel;
            o_coded = 1'b1;
         end
         PhChromaDcCr: begin
            o_job   = RsCrDcLevel;
            o_coded = 1'b1;
         end
         PhChromaAc: begin
            // counter bit 2 selects Cr after the four Cb blocks
            o_coded = w_chroma_ac;
            if (i_chroma_cnt[2]) o_job = w_chroma_ac ? RsCrAcLevel : RsCrAcLevel0;
            else                 o_job = w_chroma_ac ? RsCbAcLevel : RsCbAcLevel0;
         end
         default: o_none = 1'b1;
      endcase
   end

endmodule

// File: rtl/transform_seq.sv
// Transform handshake initiator: walks one macroblock's luma and chroma
// 4x4/DC jobs in decode order, pairing coded jobs with the residual decoder.
module transform_seq
   import transform_seq_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ena,
   input  logic       i_mb_start,
   input  logic       i_is_i16x16,
   input  logic [3:0] i_cbp_luma,
   input  logic [1:0] i_cbp_chroma,
   input  logic       i_blk_rdy,
   output logic       o_blk_ack,
   output logic       o_trans_start,
   output logic [3:0] o_trans_state,
   output logic [3:0] o_luma_idx,
   output logic [1:0] o_chroma_idx,
   input  logic       i_trans_valid,
   output logic       o_busy,
   output logic       o_mb_done
);

   seq_state_e      r_state;
   phase_e          r_phase;
   logic [4:0]      r_luma_cnt;
   logic [2:0]      r_chroma_cnt;
   logic            r_is_i16x16;
   logic [3:0]      r_cbp_luma;
   logic [1:0]      r_cbp_chroma;
   logic            r_coded;
   logic            r_busy;
   logic [3:0]      r_trans_state;
   logic [3:0]      r_luma_idx;
   logic [1:0]      r_chroma_idx;

   residual_state_e w_job;
   logic            w_coded;
   logic            w_none;
   logic [3:0]      w_luma_idx;
   logic [1:0]      w_chroma_idx;

   transform_seq_jobsel u_jobsel (
      .i_phase      (r_phase),
      .i_luma_cnt   (r_luma_cnt),
      .i_chroma_cnt (r_chroma_cnt),
      .i_cbp_luma   (r_cbp_luma),
      .i_cbp_chroma (r_cbp_chroma),
      .i_is_i16x16  (r_is_i16x16),
      .o_job        (w_job),
      .o_coded      (w_coded),
      .o_none       (w_none),
      .o_luma_idx   (w_luma_idx),
      .o_chroma_idx (w_chroma_idx)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_phase       <= PhLumaDc;
         r_luma_cnt    <= 5'd0;
         r_chroma_cnt  <= 3'd0;
         r_is_i16x16   <= 1'b0;
         r_cbp_luma    <= 4'd0;
         r_cbp_chroma  <= 2'd0;
         r_coded       <= 1'b0;
         r_busy        <= 1'b0;
         r_trans_state <= 4'd0;
         r_luma_idx    <= 4'd0;
         r_chroma_idx  <= 2'd0;
      end else if (i_ena) begin
         case (r_state)
            StIdle: begin
               if (i_mb_start) begin
                  r_is_i16x16  <= i_is_i16x16;
                  r_cbp_luma   <= i_cbp_luma;
                  r_cbp_chroma <= i_cbp_chroma;
                  r_phase      <= i_is_i16x16 ? PhLumaDc : PhLumaAc;
                  r_luma_cnt   <= 5'd0;
                  r_chroma_cnt <= 3'd0;
                  r_busy       <= 1'b1;
                  r_state      <= StSel;
               end
            end
            StSel: begin
               if (w_none) begin
                  r_busy  <= 1'b0;
                  r_state <= StDone;
               end else begin
                  r_trans_state <= w_job;
                  r_luma_idx    <= w_luma_idx;
                  r_chroma_idx  <= w_chroma_idx;
                  r_coded       <= w_coded;
                  r_state       <= w_coded ? StWaitRdy : StStart;
               end
            end
            StWaitRdy: if (i_blk_rdy) r_state <= StStart;
            StStart:   r_state <= StSettle;
            // valid is still left over from the previous job here
            StSettle:  r_state <= StWaitDone;
            StWaitDone: begin
               if (i_trans_valid) begin
                  r_state <= StSel;
                  case (r_phase)
                     PhLumaDc: r_phase <= PhLumaAc;
                     PhLumaAc: begin
                        r_luma_cnt <= r_luma_cnt + 5'd1;
                        if (r_luma_cnt == LumaLast) begin
                           r_phase <= (r_cbp_chroma != 2'd0) ? PhChromaDcCb : PhChromaAc;
                        end
                     end
                     PhChromaDcCb: r_phase <= PhChromaDcCr;
                     PhChromaDcCr: r_phase <= PhChromaAc;
                     PhChromaAc: begin
                        if (r_chroma_cnt == ChromaLast) begin
                           r_phase      <= PhNone;
                           r_chroma_cnt <= 3'd0;
                        end else begin
                           r_chroma_cnt <= r_chroma_cnt + 3'd1;
                        end
                     end
                     default: r_phase <= PhNone;
                  endcase
               end
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   // start/ack/done decode from state so they persist until an ena cycle consumes them
   assign o_trans_start = (r_state == StStart);
   assign o_blk_ack     = (r_state == StStart) && r_coded;
   assign o_mb_done     = (r_state == StDone);
   assign o_busy        = r_busy;
   assign o_trans_state = r_trans_state;
   assign o_luma_idx    = r_luma_idx;
   assign o_chroma_idx  = r_chroma_idx;

endmodule

// File: tb/tb_transform_seq.sv
// Directed bench for transform_seq: a behavioural transform/residual-decoder
// model answers the handshake; job logs are compared against expected lists.
module tb_transform_seq;
   import transform_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst, ena, mb_start, is_i16x16, blk_rdy, trans_valid;
   logic [3:0] cbp_luma;
   logic [1:0] cbp_chroma;
   logic       blk_ack, trans_start, busy, mb_done;
   logic [3:0] trans_state, luma_idx;
   logic [1:0] chroma_idx;

   transform_seq dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_ena         (ena),
      .i_mb_start    (mb_start),
      .i_is_i16x16   (is_i16x16),
      .i_cbp_luma    (cbp_luma),
      .i_cbp_chroma  (cbp_chroma),
      .i_blk_rdy     (blk_rdy),
      .o_blk_ack     (blk_ack),
      .o_trans_start (trans_start),
      .o_trans_state (trans_state),
      .o_luma_idx    (luma_idx),
      .o_chroma_idx  (chroma_idx),
      .i_trans_valid (trans_valid),
      .o_busy        (busy),
      .o_mb_done     (mb_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int q_code[$], q_luma[$], q_chroma[$];
   int a_code[$], a_luma[$], a_chroma[$];
   int e_code[$], e_luma[$], e_chroma[$], e_coded[$];
   int n_mbdone = 0, n_early = 0, n_rdy_bad = 0;
   int lat = 5, clr_dly = 0, vcnt = 0, ccnt = 0, rcnt = 0;
   bit rdy_mode = 0, ena_tog = 0, start_pend = 0, ack_pend = 0, rarm = 0, job_busy = 0;
   logic rdy_p1 = 1'b0, rdy_p2 = 1'b0;

   // Observe handshakes consumed on ena edges.
   always @(posedge clk) begin
      if (!rst && ena) begin
         if (trans_start) begin
            if (job_busy) n_early++;
            job_busy   = 1;
            start_pend = 1;
            q_code.push_back(int'(trans_state));
            q_luma.push_back(int'(luma_idx));
            q_chroma.push_back(int'(chroma_idx));
            if (blk_ack) begin
               a_code.push_back(int'(trans_state));
               a_luma.push_back(int'(luma_idx));
               a_chroma.push_back(int'(chroma_idx));
               ack_pend = 1;
               if (rdy_mode && !ena_tog && !(rdy_p1 === 1'b1 && rdy_p2 === 1'b0)) n_rdy_bad++;
            end
         end
         if (mb_done) n_mbdone++;
         if (mb_start && !busy) rarm = 1;
      end
      rdy_p2 = rdy_p1;
      rdy_p1 = blk_rdy;
   end

   // Transform and residual-decoder models, driven away from the active edge.
   always @(negedge clk) begin
      if (ena_tog) ena = ~ena;
      if (ack_pend) begin
         ack_pend = 0;
         if (rdy_mode) blk_rdy = 1'b0;
      end
      if (rdy_mode) begin
         if (rarm) rcnt = 1;
         else if (rcnt != 0) begin
            rcnt++;
            if (rcnt == 3) begin
               blk_rdy = 1'b1;
               rcnt    = 0;
            end
         end
      end
      rarm = 0;
      if (start_pend) begin
         start_pend = 0;
         ccnt = clr_dly;
         vcnt = lat;
         if (ccnt == 0) trans_valid = 1'b0;
      end else begin
         if (ccnt != 0) begin
            ccnt--;
            if (ccnt == 0) trans_valid = 1'b0;
         end
         if (vcnt != 0) begin
            vcnt--;
            if (vcnt == 0) begin
               trans_valid = 1'b1;
               job_busy    = 0;
               if (rdy_mode) rcnt = 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      assert (got === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      q_code.delete(); q_luma.delete(); q_chroma.delete();
      a_code.delete(); a_luma.delete(); a_chroma.delete();
   endtask

   task automatic push_exp(input int code, input int li, input int ci, input int coded);
      e_code.push_back(code); e_luma.push_back(li);
      e_chroma.push_back(ci); e_coded.push_back(coded);
   endtask

   // Index -1 marks a field the job does not define.
   task automatic build_exp(input logic i16, input logic [3:0] cl, input logic [1:0] cc);
      logic c;
      e_code.delete(); e_luma.delete(); e_chroma.delete(); e_coded.delete();
      if (i16) push_exp(int'(RsI16DcLevel), 0, -1, 1);
      for (int i = 0; i < 16; i++) begin
         c = cl[i/4];
         if (i16) push_exp(c ? int'(RsI16AcLevel) : int'(RsI16AcLevel0), i, -1, int'(c));
         else     push_exp(c ? int'(RsLumaLevel) : int'(RsLumaLevel0), i, -1, int'(c));
      end
      if (cc != 2'd0) begin
         push_exp(int'(RsCbDcLevel), -1, -1, 1);
         push_exp(int'(RsCrDcLevel), -1, -1, 1);
      end
      c = (cc == 2'd2);
      for (int i = 0; i < 8; i++) begin
         if (i < 4) push_exp(c ? int'(RsCbAcLevel) : int'(RsCbAcLevel0), -1, i % 4, int'(c));
         else       push_exp(c ? int'(RsCrAcLevel) : int'(RsCrAcLevel0), -1, i % 4, int'(c));
      end
   endtask

   task automatic compare_logs(input string tag);
      int k = 0;
      check($sformatf("%s starts", tag), q_code.size(), e_code.size());
      for (int i = 0; i < e_code.size() && i < q_code.size(); i++) begin
         check($sformatf("%s job%0d code", tag, i), q_code[i], e_code[i]);
         if (e_luma[i] >= 0) check($sformatf("%s job%0d luma", tag, i), q_luma[i], e_luma[i]);
         if (e_chroma[i] >= 0) check($sformatf("%s job%0d chroma", tag, i), q_chroma[i], e_chroma[i]);
      end
      for (int i = 0; i < e_code.size(); i++) begin
         if (e_coded[i] != 0) begin
            if (k < a_code.size()) begin
               check($sformatf("%s ack%0d code", tag, k), a_code[k], e_code[i]);
               if (e_luma[i] >= 0) check($sformatf("%s ack%0d luma", tag, k), a_luma[k], e_luma[i]);
               if (e_chroma[i] >= 0) check($sformatf("%s ack%0d chroma", tag, k), a_chroma[k], e_chroma[i]);
            end
            k++;
         end
      end
      check($sformatf("%s acks", tag), a_code.size(), k);
   endtask

   task automatic start_mb(input logic i16, input logic [3:0] cl, input logic [1:0] cc);
      is_i16x16  = i16;
      cbp_luma   = cl;
      cbp_chroma = cc;
      mb_start   = 1'b1;
      for (int i = 0; i < 8 && !busy; i++) tick();
      mb_start = 1'b0;
   endtask

   task automatic wait_mb(input string tag, input int d0);
      for (int i = 0; i < 3000 && n_mbdone == d0; i++) tick();
      repeat (4) tick();
      check($sformatf("%s mb_done count", tag), n_mbdone - d0, 1);
      check($sformatf("%s busy after", tag), busy, 1'b0);
      check($sformatf("%s early start", tag), n_early, 0);
   endtask

   initial begin
      int d0;
      rst = 1'b1; ena = 1'b1; mb_start = 1'b0; is_i16x16 = 1'b0;
      cbp_luma = 4'd0; cbp_chroma = 2'd0; blk_rdy = 1'b1; trans_valid = 1'b1;
      repeat (3) tick();
      check("rst trans_start", trans_start, 1'b0);
      check("rst blk_ack", blk_ack, 1'b0);
      check("rst trans_state", trans_state, 4'd0);
      check("rst luma_idx", luma_idx, 4'd0);
      check("rst chroma_idx", chroma_idx, 2'd0);
      check("rst busy", busy, 1'b0);
      check("rst mb_done", mb_done, 1'b0);
      rst = 1'b0;
      repeat (2) tick();

      // 1: Intra16x16, one coded 8x8, no chroma; mb_start while busy is ignored
      clear_logs(); d0 = n_mbdone;
      build_exp(1'b1, 4'b0001, 2'd0);
      start_mb(1'b1, 4'b0001, 2'd0);
      repeat (10) tick();
      is_i16x16 = 1'b0; cbp_luma = 4'hF; cbp_chroma = 2'd2;
      mb_start = 1'b1; tick(); mb_start = 1'b0;
      wait_mb("s1", d0);
      compare_logs("s1");
      check("s1 total starts", q_code.size(), 25);
      check("s1 total acks", a_code.size(), 5);

      // 2: all coded, blk_rdy arrives late for every block
      rdy_mode = 1; blk_rdy = 1'b0;
      clear_logs(); d0 = n_mbdone;
      build_exp(1'b0, 4'hF, 2'd2);
      start_mb(1'b0, 4'hF, 2'd2);
      wait_mb("s2", d0);
      compare_logs("s2");
      check("s2 total acks", a_code.size(), 26);
      check("s2 start after rdy", n_rdy_bad, 0);

      // 3: valid stays high into SETTLE before the model clears it
      rdy_mode = 0; tick(); blk_rdy = 1'b1; clr_dly = 1;
      clear_logs(); d0 = n_mbdone;
      build_exp(1'b1, 4'b1010, 2'd1);
      start_mb(1'b1, 4'b1010, 2'd1);
      wait_mb("s3", d0);
      compare_logs("s3");
      clr_dly = 0;

      // 4: scenario 2 with ena toggling every cycle
      rdy_mode = 1; blk_rdy = 1'b0; ena_tog = 1;
      clear_logs(); d0 = n_mbdone;
      build_exp(1'b0, 4'hF, 2'd2);
      start_mb(1'b0, 4'hF, 2'd2);
      wait_mb("s4", d0);
      compare_logs("s4");
      ena_tog = 0; tick(); ena = 1'b1;
      rdy_mode = 0; tick(); blk_rdy = 1'b1;

      // 5: reset during WAIT_DONE of job 7, then a full replay
      clear_logs();
      build_exp(1'b1, 4'b0001, 2'd0);
      start_mb(1'b1, 4'b0001, 2'd0);
      for (int i = 0; i < 500 && q_code.size() < 8; i++) tick();
      check("s5 reached job7", q_code.size(), 8);
      tick();
      #1 rst = 1'b1;
      #1;
      check("s5 rst busy", busy, 1'b0);
      check("s5 rst trans_start", trans_start, 1'b0);
      check("s5 rst blk_ack", blk_ack, 1'b0);
      check("s5 rst trans_state", trans_state, 4'd0);
      check("s5 rst luma_idx", luma_idx, 4'd0);
      check("s5 rst mb_done", mb_done, 1'b0);
      tick(); rst = 1'b0;
      repeat (10) tick();
      clear_logs(); d0 = n_mbdone;
      start_mb(1'b1, 4'b0001, 2'd0);
      wait_mb("s5", d0);
      compare_logs("s5");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
